magma_bus_arb: RTL
==================

# magma_bus_arb

Shared-bus arbiter that multiplexes several bus masters of the magma SoC onto one slave port: the udm debug master, plus the instruction and data ports of the CPU cores. It sits between the masters and the address decoder / interconnect in front of RAM and IO. It serialises transactions and routes read responses back to the issuing master. It also terminates reads that never receive a response, so the udm and the cores can never hang the bus.

## Interface
- NUM_M, 4, number of masters; index 0 is the udm master (strict priority), 1..NUM_M-1 are round-robin
- TIMEOUT, 1024, cycles to wait for a read response before forcing an error response (≥2)
- ERR_DATA, 32'hDEADBEEF, rdata returned on timeout
- clk_i  in  1  system clock
- arst_n_i  in  1  asynchronous active-low reset
- m_req_i  in  NUM_M  per-master request
- m_we_i  in  NUM_M  per-master write enable
- m_addr_bi  in  NUM_M*32  per-master address, master k at bits [32k+31:32k]
- m_be_bi  in  NUM_M*4  per-master byte enables
- m_wdata_bi  in  NUM_M*32  per-master write data
- m_ack_o  out  NUM_M  per-master request accepted (one-hot or zero)
- m_resp_o  out  NUM_M  per-master read response valid (one-hot or zero)
- m_rdata_bo  out  32  read data, shared, qualified by m_resp_o
- s_req_o, s_we_o  out  1  slave request / write enable
- s_addr_bo  out  32, s_be_bo  out  4, s_wdata_bo  out  32  slave command fields
- s_ack_i  in  1  slave accepted request
- s_resp_i  in  1  slave read response valid
- s_rdata_bi  in  32  slave read data
- grant_bo  out  NUM_M  one-hot current owner, zero in IDLE (debug visibility)
- timeout_o  out  1  one-cycle pulse when a read is force-terminated

## Operation
- FSM states: IDLE, REQ, WAIT_RESP.
- IDLE: if any m_req_i is set, select a winner and latch its index and its we/addr/be/wdata into registers. Go to REQ.
  - Master 0 wins whenever it requests.
  - Otherwise the winner is the first requester in 1..NUM_M-1, scanning cyclically from rr_ptr.
- REQ: s_req_o=1 and the slave fields are driven from the latched registers; they are held stable until s_ack_i.
  - On s_ack_i: m_ack_o[owner]=1 in the same cycle (combinational from s_ack_i and the state).
  - If the winner was a round-robin master, rr_ptr ← owner+1, wrapping from NUM_M-1 to 1. A master-0 grant leaves rr_ptr unchanged.
  - Write → IDLE. Read → WAIT_RESP, timeout counter cleared.
- WAIT_RESP: m_resp_o[owner]=s_resp_i and m_rdata_bo=s_rdata_bi, both combinational.
  - On s_resp_i → IDLE.
  - When the counter reaches TIMEOUT-1 without s_resp_i: m_resp_o[owner]=1, m_rdata_bo=ERR_DATA, timeout_o=1, → IDLE.
  - s_resp_i and timeout in the same cycle: the real response wins and timeout_o=0.
- Masters must hold req and the command fields until they see m_ack_o. Withdrawing a request after it is latched is a protocol violation; the latched transaction still completes.
- s_resp_i in IDLE or REQ (a late response after a timeout) is dropped, with no m_resp_o.
- Only one transaction is ever outstanding.

## Timing
- Reset values: state IDLE, rr_ptr=1, all outputs 0, latched registers 0. Reset asserted mid-transaction aborts it immediately with no ack or resp.
- Request-to-slave latency: m_req_i sampled high at edge t → s_req_o high after edge t (one register stage).
- Back-to-back grants:
  - Write: ack at cycle c, IDLE at c+1, next s_req_o at c+2 (2-cycle minimum issue interval).
  - Read: next s_req_o at the cycle after resp + 1.
- Timeout response appears exactly TIMEOUT cycles after the cycle of s_ack_i.
- The arbitration decision is taken only in IDLE; requests that arrive during REQ or WAIT_RESP wait.

## Structure
- Package magma_arb_pkg holds: the state enum (IDLE, REQ, WAIT_RESP), the ERR_DATA default, and the widths ADDR_W=32, DATA_W=32, BE_W=4.
- Sub-module magma_rr_picker: combinational rotating priority encoder with inputs req[NUM_M-1:1] and ptr, and outputs valid and idx. The fixed priority for master 0 stays in the top level.

## Test plan
- Single udm write to 0x00000000, data 0x123455AA, slave acks after 3 cycles → s_req_o one cycle after m_req_i, fields stable until ack, m_ack_o[0] coincides with s_ack_i, no m_resp_o.
- Masters 1, 2 and 3 request writes continuously, slave acks immediately → grant order 1,2,3,1,2,3; each grant 2 cycles apart.
- Masters 0 and 2 request simultaneously with rr_ptr=1 → master 0 granted first, then 2; rr_ptr=3 afterwards.
- Master 1 reads 0x40000010, slave returns 0x000000CC 5 cycles after ack → m_resp_o[1] pulse with m_rdata_bo=0x000000CC; other m_resp_o bits stay 0.
- Read with no slave response, TIMEOUT=16 → m_resp_o[owner] and timeout_o at ack+16, m_rdata_bo=0xDEADBEEF; a late s_resp_i 3 cycles later is ignored.
- arst_n_i pulsed low during WAIT_RESP → all outputs 0, state IDLE, rr_ptr=1; the next request is served normally.

Source files
------------

// File: rtl/magma_arb_pkg.sv
// Shared definitions for the magma bus arbiter: FSM states, bus field widths
// and the read data returned when a read is force-terminated.
package magma_arb_pkg;

  localparam int ADDR_W = 32;
  localparam int DATA_W = 32;
  localparam int BE_W   = 4;

  localparam logic [DATA_W-1:0] ERR_DATA_DEF = 32'hDEADBEEF;

  typedef enum logic [1:0] {
    IDLE      = 2'd0,
    REQ       = 2'd1,
    WAIT_RESP = 2'd2
  } arb_state_e;

endpackage

// File: rtl/magma_rr_picker.sv
// Rotating priority encoder over the round-robin masters 1..NUM_M-1: returns the
// first requester found when scanning cyclically upward from ptr.
module magma_rr_picker #(
  parameter int NUM_M = 4,
  parameter int IW    = 2
) (
  input  logic [NUM_M-1:1] req,
  input  logic [IW-1:0]    ptr,
  output logic             valid,
  output logic [IW-1:0]    idx
);

  // Walk the scan order backwards so the nearest requester to ptr is written last.
  always_comb begin
    valid = 1'b0;
    idx   = {IW{1'b0}};
    for (int k = NUM_M - 2; k >= 0; k--) begin
      logic [IW-1:0] cand;
      cand  = IW'(((int'(ptr) - 1 + k) % (NUM_M - 1)) + 1);
      valid = valid | req[cand];
      idx   = req[cand] ? cand : idx;
    end
  end

endmodule

// File: rtl/magma_bus_arb.sv
// Shared-bus arbiter: udm master 0 has strict priority, the core ports share the
// rest round-robin; one transaction in flight, reads bounded by a response timeout.
module magma_bus_arb
  import magma_arb_pkg::*;
#(
  parameter int                NUM_M    = 4,
  parameter int                TIMEOUT  = 1024,
  parameter logic [DATA_W-1:0] ERR_DATA = ERR_DATA_DEF
) (
  input  logic                      clk_i,
  input  logic                      arst_n_i,
  input  logic [NUM_M-1:0]          m_req_i,
  input  logic [NUM_M-1:0]          m_we_i,
  input  logic [NUM_M*ADDR_W-1:0]   m_addr_bi,
  input  logic [NUM_M*BE_W-1:0]     m_be_bi,
  input  logic [NUM_M*DATA_W-1:0]   m_wdata_bi,
  output logic [NUM_M-1:0]          m_ack_o,
  output logic [NUM_M-1:0]          m_resp_o,
  output logic [DATA_W-1:0]         m_rdata_bo,
  output logic                      s_req_o,
  output logic                      s_we_o,
  output logic [ADDR_W-1:0]         s_addr_bo,
  output logic [BE_W-1:0]           s_be_bo,
  output logic [DATA_W-1:0]         s_wdata_bo,
  input  logic                      s_ack_i,
  input  logic                      s_resp_i,
  input  logic [DATA_W-1:0]         s_rdata_bi,
  output logic [NUM_M-1:0]          grant_bo,
  output logic                      timeout_o
);

  localparam int              IW       = $clog2(NUM_M);
  localparam int              CW       = $clog2(TIMEOUT);
  localparam logic [CW-1:0]   CNT_LAST = CW'(TIMEOUT - 1);
  localparam logic [IW-1:0]   RR_FIRST = IW'(1);
  localparam logic [IW-1:0]   RR_LAST  = IW'(NUM_M - 1);

  arb_state_e          state_r;
  logic [IW-1:0]       owner_r;
  logic [IW-1:0]       rr_ptr_r;
  logic [CW-1:0]       cnt_r;
  logic                s_req_r;
  logic                we_r;
  logic [ADDR_W-1:0]   addr_r;
  logic [BE_W-1:0]     be_r;
  logic [DATA_W-1:0]   wdata_r;
  logic [NUM_M-1:0]    grant_r;

  logic                pick_valid_s;
  logic [IW-1:0]       pick_idx_s;
  logic [IW-1:0]       win_s;
  logic                any_req_s;
  logic                ack_s;
  logic                tmo_s;
  logic                resp_s;

  magma_rr_picker #(
    .NUM_M (NUM_M),
    .IW    (IW)
  ) u_rr_picker (
    .req   (m_req_i[NUM_M-1:1]),
    .ptr   (rr_ptr_r),
    .valid (pick_valid_s),
    .idx   (pick_idx_s)
  );

  // Winner selection: the udm master overrides the round-robin pick.
  always_comb begin
    win_s     = pick_idx_s;
    any_req_s = m_req_i[0] | pick_valid_s;
    if (m_req_i[0]) begin
      win_s = {IW{1'b0}};
    end else begin
      win_s = pick_idx_s;
    end
  end

  assign ack_s  = (state_r == REQ) & s_ack_i;
  assign tmo_s  = (state_r == WAIT_RESP) & ~s_resp_i & (cnt_r == CNT_LAST);
  assign resp_s = (state_r == WAIT_RESP) & (s_resp_i | tmo_s);

  // Master-side handshakes follow the slave in the same cycle; a real response beats the timeout.
  always_comb begin
    m_ack_o           = {NUM_M{1'b0}};
    m_resp_o          = {NUM_M{1'b0}};
    m_ack_o[owner_r]  = ack_s;
    m_resp_o[owner_r] = resp_s;
    if (state_r == WAIT_RESP) begin
      m_rdata_bo = tmo_s ? ERR_DATA : s_rdata_bi;
    end else begin
      m_rdata_bo = {DATA_W{1'b0}};
    end
  end

  assign timeout_o  = tmo_s;
  assign s_req_o    = s_req_r;
  assign s_we_o     = we_r;
  assign s_addr_bo  = addr_r;
  assign s_be_bo    = be_r;
  assign s_wdata_bo = wdata_r;
  assign grant_bo   = grant_r;

  // Arbitration FSM: latch the winner in IDLE, hold the command until ack, then wait for read data.
  always_ff @(posedge clk_i or negedge arst_n_i) begin
    if (!arst_n_i) begin
      state_r  <= IDLE;
      owner_r  <= {IW{1'b0}};
      rr_ptr_r <= RR_FIRST;
      cnt_r    <= {CW{1'b0}};
      s_req_r  <= 1'b0;
      we_r     <= 1'b0;
      addr_r   <= {ADDR_W{1'b0}};
      be_r     <= {BE_W{1'b0}};
      wdata_r  <= {DATA_W{1'b0}};
      grant_r  <= {NUM_M{1'b0}};
    end else begin
      case (state_r)
        IDLE: begin
          if (any_req_s) begin
            owner_r <= win_s;
            we_r    <= m_we_i[win_s];
            addr_r  <= m_addr_bi[int'(win_s)*ADDR_W +: ADDR_W];
            be_r    <= m_be_bi[int'(win_s)*BE_W +: BE_W];
            wdata_r <= m_wdata_bi[int'(win_s)*DATA_W +: DATA_W];
            grant_r <= NUM_M'(1) << win_s;
            s_req_r <= 1'b1;
            state_r <= REQ;
          end
        end
        REQ: begin
          if (s_ack_i) begin
            s_req_r <= 1'b0;
            if (owner_r != {IW{1'b0}}) begin
              rr_ptr_r <= (owner_r == RR_LAST) ? RR_FIRST : owner_r + IW'(1);
            end
            if (we_r) begin
              grant_r <= {NUM_M{1'b0}};
              state_r <= IDLE;
            end else begin
              cnt_r   <= {CW{1'b0}};
              state_r <= WAIT_RESP;
            end
          end
        end
        WAIT_RESP: begin
          if (s_resp_i || (cnt_r == CNT_LAST)) begin
            grant_r <= {NUM_M{1'b0}};
            state_r <= IDLE;
          end else begin
            cnt_r <= cnt_r + CW'(1);
          end
        end
        default: begin
          s_req_r <= 1'b0;
          grant_r <= {NUM_M{1'b0}};
          state_r <= IDLE;
        end
      endcase
    end
  end

endmodule
